// File: rtl/vc_random_delay_ctrl.sv
// vc_random_delay_ctrl: one-entry val/rdy stage that holds every accepted
// message for a pseudo-random number of cycles before offering it downstream.
// The delay comes from an internal 32-bit xorshift-style PRNG. The PRNG
// advances only when a message is accepted.
// Optional feature: define VC_RANDOM_DELAY_CTRL_STATS_EN to add the 32-bit
// stall_count output. It counts cycles spent in WAIT, plus cycles in SEND
// while out_rdy is low.
module vc_random_delay_ctrl #(
    parameter int unsigned p_msg_nbits   = 32,
    parameter int unsigned p_delay_nbits = 3,
    parameter logic [31:0] p_seed        = 32'hdeadbeef
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_val,
    output logic                   in_rdy,
    input  logic [p_msg_nbits-1:0] in_msg,
    output logic                   out_val,
    input  logic                   out_rdy,
    output logic [p_msg_nbits-1:0] out_msg
`ifdef VC_RANDOM_DELAY_CTRL_STATS_EN
    ,
    output logic [31:0]            stall_count
`else
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_SEND = 2'd2
    } state_e;

    localparam logic [p_delay_nbits-1:0] cnt_one_c = p_delay_nbits'(1);

    state_e                   state_q, state_d;
    logic [p_delay_nbits-1:0] cnt_q, cnt_d;
    logic [p_msg_nbits-1:0]   msg_q, msg_d;
    logic [31:0]              prng_q, prng_d;
    logic [p_delay_nbits-1:0] delay_s;

    // Next PRNG value: t = (r >> 17) ^ r, then t ^ (t << 15).
    function automatic logic [31:0] prng_next(input logic [31:0] r);
        logic [31:0] t;
        t = (r >> 5'd17) ^ r;
        return t ^ (t << 5'd15);
    endfunction

    // Fold the low 31 bits of r into one delay value by XORing every whole
    // p_delay_nbits-wide slice. Bit 31 is never used, and neither is a
    // partial top slice.
    function automatic logic [p_delay_nbits-1:0] delay_of(input logic [31:0] r);
        logic [p_delay_nbits-1:0] d;
        d = r[p_delay_nbits-1:0];
        for (int i = 2 * p_delay_nbits - 1; i < 31; i = i + p_delay_nbits) begin
            d = d ^ r[i -: p_delay_nbits];
        end
        return d;
    endfunction

    assign delay_s = delay_of(prng_q);

    // Every output is decoded from registered state only, so nothing passes
    // combinationally from an input to an output.
    assign in_rdy  = (state_q == ST_IDLE);
    assign out_val = (state_q == ST_SEND);
    assign out_msg = msg_q;

    // State, counter, message and PRNG registers; reset drops any held message.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            msg_q   <= '0;
            prng_q  <= p_seed;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            msg_q   <= msg_d;
            prng_q  <= prng_d;
        end
    end

    // Next-state logic: accept in IDLE, count down in WAIT, hold in SEND until the handshake.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        msg_d   = msg_q;
        prng_d  = prng_q;
        case (state_q)
            ST_IDLE: begin
                if (in_val) begin
                    msg_d  = in_msg;
                    prng_d = prng_next(prng_q);
                    if (delay_s == '0) begin
                        state_d = ST_SEND;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = delay_s;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - cnt_one_c;
                if (cnt_q == cnt_one_c) begin
                    state_d = ST_SEND;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_SEND: begin
                if (out_rdy) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_SEND;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

`ifdef VC_RANDOM_DELAY_CTRL_STATS_EN
    logic [31:0] stall_count_q, stall_count_d;

    assign stall_count = stall_count_q;

    // Stall counter: count WAIT cycles and back-pressured SEND cycles, wrapping at 2^32.
    always_comb begin
        stall_count_d = stall_count_q;
        if ((state_q == ST_WAIT) || ((state_q == ST_SEND) && !out_rdy)) begin
            stall_count_d = stall_count_q + 32'd1;
        end else begin
            stall_count_d = stall_count_q;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_count_q <= 32'd0;
        end else begin
            stall_count_q <= stall_count_d;
        end
    end
`else
`endif

endmodule

// File: doc/vc_random_delay_ctrl.md
VC_RANDOM_DELAY_CTRL -- requirements
Module: vc_random_delay_ctrl

Interface
REQ-001 Parameter p_msg_nbits, default 32: message width in bits.
REQ-002 Parameter p_delay_nbits, default 3: delay field width; delay range 0..2^p_delay_nbits-1; legal range 1..8.
REQ-003 Parameter p_seed, default 32'hdeadbeef: PRNG seed, 32 bits.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 in_val  input  1  upstream message valid.
REQ-007 in_rdy  output  1  block can accept a message.
REQ-008 in_msg  input  p_msg_nbits  upstream message.
REQ-009 out_val  output  1  downstream message valid.
REQ-010 out_rdy  input  1  downstream can accept.
REQ-011 out_msg  output  p_msg_nbits  buffered message.

Function
REQ-012 The block SHALL be a one-entry val/rdy stage that holds each accepted message for a pseudo-random number of cycles before offering it downstream.
REQ-013 The PRNG SHALL be an internal 32-bit register r with next value t^(t<<15), where t = (r>>17)^r.
REQ-014 Delay d SHALL be r[p_delay_nbits-1:0] XORed with every slice r[i -: p_delay_nbits] for i = 2*p_delay_nbits-1, stepping by p_delay_nbits, while i < 31.
REQ-015 d SHALL be computed from r as it stands in the acceptance cycle; r SHALL advance exactly once, at the edge ending that cycle, and at no other time.
REQ-016 FSM states: IDLE, WAIT, SEND.
REQ-017 IDLE: in_rdy=1, out_val=0; on in_val=1, capture in_msg; go to SEND if d=0, else to WAIT with counter=d.
REQ-018 WAIT: in_rdy=0, out_val=0; counter decrements once per cycle; at the edge where it decrements from 1 to 0, go to SEND.
REQ-019 SEND: out_val=1, in_rdy=0, out_msg=captured message; on out_rdy=1, go to IDLE. Otherwise hold.
REQ-020 Latency: a message accepted in cycle N SHALL first show out_val=1 in cycle N+1+d.
REQ-021 out_msg SHALL stay stable from entry into SEND until the output handshake completes; in_msg SHALL be ignored outside IDLE.
REQ-022 Peak throughput SHALL be one message per two cycles (d=0, out_rdy held 1); there is no same-cycle bypass and no in_rdy/out_val overlap.
REQ-023 out_rdy=1 in IDLE or WAIT SHALL have no effect.

Reset
REQ-024 Asserting reset SHALL immediately set: FSM=IDLE, counter=0, r=p_seed, captured message=0.
REQ-025 Output values during and after reset: in_rdy=1, out_val=0, out_msg=0.
REQ-026 Reset during WAIT or SEND SHALL discard the buffered message; it is never emitted.
REQ-027 The first acceptance after reset deassertion SHALL use d derived from p_seed.

Configuration
REQ-028 Macro VC_RANDOM_DELAY_CTRL_STATS_EN, when defined, SHALL add output port stall_count (32 bits). The counter increments each cycle the FSM is in WAIT, or in SEND with out_rdy=0.
REQ-029 stall_count SHALL reset to 0, wrap modulo 2^32, and count no cycles in IDLE.
REQ-030 Without the macro, port stall_count and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-031 Defaults; reset; in_val=1, in_msg=0x12345678 in cycle N; out_rdy=1 → d=5; out_val first high in cycle N+6 with out_msg=0x12345678; in_rdy=0 during cycles N+1..N+6.
REQ-032 Send 100 back-to-back messages with out_rdy=1 → the output sequence equals the input sequence, and each latency matches a software model of REQ-013/014.
REQ-033 In SEND, hold out_rdy=0 for 10 cycles and change in_msg every cycle → out_val stays 1, out_msg is unchanged, in_rdy stays 0; raise out_rdy → exactly one handshake, then IDLE.
REQ-034 Assert reset mid-WAIT for 1 cycle → in_rdy=1 and out_val=0 immediately; the dropped message never appears; the next delay equals the first delay after reset (5).
REQ-035 p_delay_nbits=1, 50 messages → every latency is 1 or 2 cycles, both values occur, and each matches the model.
REQ-036 Macro defined, scenario REQ-031 plus 3 cycles with out_rdy=0 in SEND → stall_count=8 after the handshake; it reads 0 after reset.
